// File: rtl/block_acc_pkg.sv
// Shared types and constants for the block accumulator.
// State encoding and arithmetic mode selectors.
package block_acc_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ACCUM = 1'b0;
   localparam state_t HOLD  = 1'b1;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/block_accumulator_sat_adder.sv
// Combinational W-bit adder with optional saturation.
// carry reports the unclipped overflow in either mode.
module sat_adder
   import block_acc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sat,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W:0] full;

   always_comb begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[W];
      if (sat == MODE_SAT && carry)
         sum = '1;
      else
         sum = full[W-1:0];
   end

endmodule

// File: rtl/block_accumulator.sv
// Sums BLOCK_LEN samples per block and hands the sum downstream.
// Define BLOCK_ACC_OVF_FLAG_EN to add the per-block ovf output.
module block_accumulator
   import block_acc_pkg::*;
#(
   parameter int IN_W      = 4,
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 4,
   localparam int CW       = $clog2(BLOCK_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             sat_mode,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef BLOCK_ACC_OVF_FLAG_EN
   output logic [CW-1:0]    count,
   output logic             ovf
`else
   output logic [CW-1:0]    count
`endif
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic [CW-1:0]    count_nxt;
   logic             last;

   sat_adder #(
      .W(ACC_W)
   ) u_add (
      .a    (acc),
      .b    (ACC_W'(in_data)),
      .sat  (sat_mode),
      .sum  (sum),
      .carry(carry)
   );

   assign count_nxt = count + CW'(1);
   assign last      = (count_nxt == CW'(BLOCK_LEN));
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ACCUM;
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
      end else if (clr) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
      end else begin
         unique case (1'b1)
            (state == ACCUM): begin
               if (in_valid) begin
                  acc   <= sum;
                  count <= count_nxt;
                  if (last) begin
                     state    <= HOLD;
                     out_data <= sum;
                  end
               end
            end
            (state == HOLD): begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= '0;
                  count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BLOCK_ACC_OVF_FLAG_EN
   // ovf_blk collects carries until the block closes into ovf
   logic ovf_blk;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         ovf_blk <= 1'b0;
         ovf     <= 1'b0;
      end else if (state == ACCUM && in_valid) begin
         ovf_blk <= ovf_blk | carry;
         if (last)
            ovf <= ovf_blk | carry;
      end else if (state == HOLD && out_ready) begin
         ovf_blk <= 1'b0;
         ovf     <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_block_accumulator.sv
// Directed bench for block_accumulator with three configurations
// sharing one stimulus bus: 4/8/4, 4/5/4 and 4/8/1.
module tb_block_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       sat_mode;
   logic [3:0] in_data;
   logic       in_valid;
   logic       out_ready;

   logic       a_in_ready, a_out_valid;
   logic [7:0] a_out_data;
   logic [2:0] a_count;
   logic       b_in_ready, b_out_valid;
   logic [4:0] b_out_data;
   logic [2:0] b_count;
   logic       c_in_ready, c_out_valid;
   logic [7:0] c_out_data;
   logic [0:0] c_count;
`ifdef BLOCK_ACC_OVF_FLAG_EN
   logic       a_ovf, b_ovf, c_ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   block_accumulator #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(4)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .sat_mode(sat_mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid),
      .out_ready(out_ready),
`ifdef BLOCK_ACC_OVF_FLAG_EN
      .count(a_count), .ovf(a_ovf)
`else
      .count(a_count)
`endif
   );

   block_accumulator #(.IN_W(4), .ACC_W(5), .BLOCK_LEN(4)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .sat_mode(sat_mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(out_ready),
`ifdef BLOCK_ACC_OVF_FLAG_EN
      .count(b_count), .ovf(b_ovf)
`else
      .count(b_count)
`endif
   );

   block_accumulator #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(1)) dut_c (
      .clk(clk), .rst(rst), .clr(clr), .sat_mode(sat_mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(c_in_ready),
      .out_data(c_out_data), .out_valid(c_out_valid),
      .out_ready(out_ready),
`ifdef BLOCK_ACC_OVF_FLAG_EN
      .count(c_count), .ovf(c_ovf)
`else
      .count(c_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      clr = 1'b0; sat_mode = 1'b0; in_data = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      do_reset();
      checks++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b0, 8'd0, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL reset got v=%0b d=%0d c=%0d r=%0b exp v=0 d=0 c=0 r=1",
                  a_out_valid, a_out_data, a_count, a_in_ready);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(4'd3);
      checks++;
      if (a_count !== 3'd1) begin
         failures++;
         $display("FAIL basic_count1 got=%0d exp=1", a_count);
      end
      send(4'd5); send(4'd7); send(4'd9);
      checks++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b1, 8'd24, 3'd4, 1'b0}) begin
         failures++;
         $display("FAIL basic_result got v=%0b d=%0d c=%0d r=%0b exp v=1 d=24 c=4 r=0",
                  a_out_valid, a_out_data, a_count, a_in_ready);
      end
`ifdef BLOCK_ACC_OVF_FLAG_EN
      checks++;
      if (a_ovf !== 1'b0) begin
         failures++;
         $display("FAIL basic_ovf got=%0b exp=0", a_ovf);
      end
`endif
      tick();
      checks++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b0, 8'd24, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL basic_release got v=%0b d=%0d c=%0d r=%0b exp v=0 d=24 c=0 r=1",
                  a_out_valid, a_out_data, a_count, a_in_ready);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd15);
      in_valid = 1'b1;
      in_data  = 4'd7;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b1, 8'd60, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL bp_hold[%0d] got v=%0b d=%0d c=%0d r=%0b exp v=1 d=60 c=4 r=0",
                     i, a_out_valid, a_out_data, a_count, a_in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if ({a_out_valid, a_count, a_in_ready} !== {1'b0, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL bp_release got v=%0b c=%0d r=%0b exp v=0 c=0 r=1",
                  a_out_valid, a_count, a_in_ready);
      end
      for (int i = 0; i < 4; i++) send(4'd1);
      checks++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'd4}) begin
         failures++;
         $display("FAIL bp_next got v=%0b d=%0d exp v=1 d=4", a_out_valid, a_out_data);
      end
      tick();
   endtask

   task automatic test_wrap_sat();
      do_reset();
      out_ready = 1'b1;
      sat_mode  = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd15);
      checks++;
      if ({b_out_valid, b_out_data} !== {1'b1, 5'd28}) begin
         failures++;
         $display("FAIL wrap got v=%0b d=%0d exp v=1 d=28", b_out_valid, b_out_data);
      end
`ifdef BLOCK_ACC_OVF_FLAG_EN
      checks++;
      if (b_ovf !== 1'b1) begin
         failures++;
         $display("FAIL wrap_ovf got=%0b exp=1", b_ovf);
      end
`endif
      tick();
      sat_mode = 1'b1;
      for (int i = 0; i < 4; i++) send(4'd15);
      checks++;
      if ({b_out_valid, b_out_data} !== {1'b1, 5'd31}) begin
         failures++;
         $display("FAIL sat got v=%0b d=%0d exp v=1 d=31", b_out_valid, b_out_data);
      end
`ifdef BLOCK_ACC_OVF_FLAG_EN
      checks++;
      if (b_ovf !== 1'b1) begin
         failures++;
         $display("FAIL sat_ovf got=%0b exp=1", b_ovf);
      end
`endif
      tick();
      sat_mode = 1'b0;
   endtask

   task automatic test_clr();
      do_reset();
      out_ready = 1'b1;
      send(4'd2); send(4'd2);
      checks++;
      if (a_count !== 3'd2) begin
         failures++;
         $display("FAIL clr_pre got=%0d exp=2", a_count);
      end
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd9;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({a_count, a_in_ready, a_out_valid} !== {3'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL clr_post got c=%0d r=%0b v=%0b exp c=0 r=1 v=0",
                  a_count, a_in_ready, a_out_valid);
      end
      send(4'd1); send(4'd2); send(4'd3); send(4'd4);
      checks++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'd10}) begin
         failures++;
         $display("FAIL clr_block got v=%0b d=%0d exp v=1 d=10", a_out_valid, a_out_data);
      end
      tick();
   endtask

   task automatic test_reset_hold();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd5);
      checks++;
      if ({a_out_valid, a_out_data} !== {1'b1, 8'd20}) begin
         failures++;
         $display("FAIL rh_pending got v=%0b d=%0d exp v=1 d=20", a_out_valid, a_out_data);
      end
      do_reset();
      checks++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b0, 8'd0, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL rh_after got v=%0b d=%0d c=%0d r=%0b exp v=0 d=0 c=0 r=1",
                  a_out_valid, a_out_data, a_count, a_in_ready);
      end
   endtask

   task automatic test_block_len1();
      do_reset();
      out_ready = 1'b1;
      send(4'd6);
      checks++;
      if ({c_out_valid, c_out_data, c_in_ready} !== {1'b1, 8'd6, 1'b0}) begin
         failures++;
         $display("FAIL bl1_first got v=%0b d=%0d r=%0b exp v=1 d=6 r=0",
                  c_out_valid, c_out_data, c_in_ready);
      end
      tick();
      checks++;
      if ({c_out_valid, c_in_ready, c_count} !== {1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL bl1_release got v=%0b r=%0b c=%0d exp v=0 r=1 c=0",
                  c_out_valid, c_in_ready, c_count);
      end
      tick(); tick();
      send(4'd9);
      checks++;
      if ({c_out_valid, c_out_data} !== {1'b1, 8'd9}) begin
         failures++;
         $display("FAIL bl1_second got v=%0b d=%0d exp v=1 d=9", c_out_valid, c_out_data);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap_sat();
      test_clr();
      test_reset_hold();
      test_block_len1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
